// File: rtl/vote_result_reader.sv
// vote_result_reader: drives a voting machine through result mode, presses
// each candidate button in turn, latches the four counts from the led bus,
// then reports the winning candidate and whether the maximum is shared.
module vote_result_reader #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] led_in,
  output logic       mode,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       button4,
  output logic [7:0] count1,
  output logic [7:0] count2,
  output logic [7:0] count3,
  output logic [7:0] count4,
  output logic [1:0] winner,
  output logic       tie,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    PRESS   = 3'd2,
    RELEASE = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Terminal values of the per-state cycle counter.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 32'd1);

  state_t      state_r;
  logic [1:0]  k_r;
  logic [7:0]  cnt_r;
  logic [3:0]  btn_r;

  // Index of the largest count; strict compare keeps the lowest index on ties.
  function automatic logic [1:0] calc_winner(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
    logic [7:0] best;
    logic [1:0] idx;
    best = a;
    idx  = 2'd0;
    if (b > best) begin
      best = b;
      idx  = 2'd1;
    end
    if (c > best) begin
      best = c;
      idx  = 2'd2;
    end
    if (d > best) begin
      idx  = 2'd3;
    end
    return idx;
  endfunction

  // Set when at least two counts equal the maximum (all-zero counts as a tie).
  function automatic logic calc_tie(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c, input logic [7:0] d);
    logic [7:0] m;
    logic [2:0] n;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    n = 3'(a == m) + 3'(b == m) + 3'(c == m) + 3'(d == m);
    return (n >= 3'd2);
  endfunction

  // One-hot button pattern for candidate index k.
  function automatic logic [3:0] button_of(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  assign button1 = btn_r[0];
  assign button2 = btn_r[1];
  assign button3 = btn_r[2];
  assign button4 = btn_r[3];

  // Readout sequencer with registered outputs; each state's outputs are set
  // on the edge that enters it, so buttons always drop before k advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      k_r     <= 2'd0;
      cnt_r   <= 8'd0;
      btn_r   <= 4'b0000;
      mode    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tie     <= 1'b0;
      winner  <= 2'd0;
      count1  <= 8'd0;
      count2  <= 8'd0;
      count3  <= 8'd0;
      count4  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= ENTER;
            k_r     <= 2'd0;
            cnt_r   <= 8'd0;
            btn_r   <= 4'b0000;
            mode    <= 1'b1;
            busy    <= 1'b1;
            tie     <= 1'b0;
            winner  <= 2'd0;
            count1  <= 8'd0;
            count2  <= 8'd0;
            count3  <= 8'd0;
            count4  <= 8'd0;
          end else begin
            mode  <= 1'b0;
            busy  <= 1'b0;
            btn_r <= 4'b0000;
          end
        end
        ENTER: begin
          if (cnt_r == GAP_LAST) begin
            state_r <= PRESS;
            cnt_r   <= 8'd0;
            btn_r   <= button_of(k_r);
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        PRESS: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r <= RELEASE;
            cnt_r   <= 8'd0;
            btn_r   <= 4'b0000;
            case (k_r)
              2'd0:    count1 <= led_in;
              2'd1:    count2 <= led_in;
              2'd2:    count3 <= led_in;
              default: count4 <= led_in;
            endcase
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RELEASE: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= 8'd0;
            if (k_r == 2'd3) begin
              state_r <= COMPARE;
              mode    <= 1'b0;
            end else begin
              state_r <= PRESS;
              k_r     <= k_r + 2'd1;
              btn_r   <= button_of(k_r + 2'd1);
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        COMPARE: begin
          state_r <= DONE;
          winner  <= calc_winner(count1, count2, count3, count4);
          tie     <= calc_tie(count1, count2, count3, count4);
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          k_r     <= 2'd0;
          cnt_r   <= 8'd0;
          btn_r   <= 4'b0000;
          mode    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_reader.sv
// Scoreboard bench for vote_result_reader with a behavioural voting machine.
module tb_vote_result_reader;

  localparam int S   = 4;
  localparam int G   = 2;
  localparam int LAT = G + 4 * (S + G) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] led_in;
  logic       mode, button1, button2, button3, button4;
  logic [7:0] count1, count2, count3, count4;
  logic [1:0] winner;
  logic       tie, busy, done;

  vote_result_reader #(.SETTLE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .start(start), .led_in(led_in),
    .mode(mode), .button1(button1), .button2(button2), .button3(button3),
    .button4(button4), .count1(count1), .count2(count2), .count3(count3),
    .count4(count4), .winner(winner), .tie(tie), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Voting machine model: led shows the held candidate's count one cycle later.
  logic [7:0] vm [4];
  always @(posedge clk) begin
    if (mode && button1)      led_in <= vm[0];
    else if (mode && button2) led_in <= vm[1];
    else if (mode && button3) led_in <= vm[2];
    else if (mode && button4) led_in <= vm[3];
    else                      led_in <= 8'h00;
  end

  typedef struct packed {
    logic [7:0] a, b, c, d;
    logic [1:0] w;
    logic       t;
  } vec_t;

  typedef struct {
    vec_t v;
    int   dc;
  } exp_t;

  exp_t q[$];
  vec_t vt[7];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor state
  logic [3:0] btn, prev_btn = 4'b0000;
  logic       prev_mode = 1'b0, prev_reset = 1'b1;
  int run_len = 0, mode_len = 0, presses = 0, done_cnt = 0, next_btn = 0;
  logic [3:0] viol;
  exp_t e;

  always @(negedge clk) begin
    btn = {button4, button3, button2, button1};
    if (reset || prev_reset) begin
      run_len  = 0;
      mode_len = 0;
      next_btn = 0;
    end else begin
      viol = 4'b0000;
      if ($countones(btn) > 1) viol[0] = 1'b1;
      if (prev_btn != 4'b0000 && btn != 4'b0000 && btn != prev_btn) viol[1] = 1'b1;
      if (btn != 4'b0000 && !mode) viol[2] = 1'b1;
      if (prev_mode && !mode && prev_btn != 4'b0000) viol[3] = 1'b1;
      chk("protocol", 32'(viol), 32'd0);
      if (btn != 4'b0000 && prev_btn == 4'b0000) begin
        presses++;
        chk("btn_order", 32'(btn), 32'(4'b0001 << next_btn));
        next_btn = (next_btn + 1) % 4;
        run_len  = 1;
      end else if (btn != 4'b0000) begin
        run_len++;
      end
      if (prev_btn != 4'b0000 && btn == 4'b0000) chk("btn_len", run_len, S);
      if (mode) mode_len++;
      if (prev_mode && !mode) begin
        chk("mode_len", mode_len, LAT - 1);
        mode_len = 0;
      end
    end
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.dc);
        chk("count1", count1, e.v.a);
        chk("count2", count2, e.v.b);
        chk("count3", count3, e.v.c);
        chk("count4", count4, e.v.d);
        chk("winner", winner, e.v.w);
        chk("tie", tie, e.v.t);
        chk("busy_at_done", busy, 1'b0);
      end
    end
    prev_btn   = btn;
    prev_mode  = mode;
    prev_reset = reset;
  end

  task automatic load_vm(input vec_t v);
    vm[0] = v.a; vm[1] = v.b; vm[2] = v.c; vm[3] = v.d;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int i;
    for (i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  // Called at posedge+1. Optionally re-pulses start 10 cycles into the run.
  task automatic run_readout(input vec_t v, input bit extra_start);
    exp_t x;
    int base, p0, d0;
    load_vm(v);
    x.v = v;
    x.dc = cyc + 1 + LAT;
    q.push_back(x);
    base = cyc; p0 = presses; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (extra_start) begin
      while (cyc < base + 10) begin
        @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_dones(d0 + 1, 100);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("press_count", presses - p0, 4);
    chk("done_count", done_cnt - d0, 1);
    chk("hold_count1", count1, v.a);
    chk("hold_count4", count4, v.d);
    chk("hold_winner", winner, v.w);
    chk("hold_tie", tie, v.t);
  endtask

  initial begin
    int base, d0, p0;
    exp_t x;
    vt[0] = '{a: 8'd3,  b: 8'd7,   c: 8'd2,   d: 8'd5,   w: 2'd1, t: 1'b0};
    vt[1] = '{a: 8'd9,  b: 8'd4,   c: 8'd9,   d: 8'd1,   w: 2'd0, t: 1'b1};
    vt[2] = '{a: 8'd0,  b: 8'd0,   c: 8'd0,   d: 8'd0,   w: 2'd0, t: 1'b1};
    vt[3] = '{a: 8'd10, b: 8'd200, c: 8'd255, d: 8'd255, w: 2'd2, t: 1'b1};
    vt[4] = '{a: 8'd1,  b: 8'd2,   c: 8'd3,   d: 8'd4,   w: 2'd3, t: 1'b0};
    vt[5] = '{a: 8'd255, b: 8'd0,  c: 8'd0,   d: 8'd0,   w: 2'd0, t: 1'b0};
    vt[6] = '{a: 8'd0,  b: 8'd0,   c: 8'd0,   d: 8'd1,   w: 2'd3, t: 1'b0};
    load_vm(vt[2]);
    led_in = 8'h00;
    reset = 1'b1;
    start = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_mode", mode, 1'b0);
    chk("idle_buttons", {button4, button3, button2, button1}, 4'b0000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_counts", {count1, count2, count3, count4}, 32'd0);
    chk("idle_winner_tie", {winner, tie}, 3'd0);

    // Directed readouts
    for (int i = 0; i < 7; i++) run_readout(vt[i], 1'b0);

    // Second start while busy is ignored
    run_readout(vt[0], 1'b1);

    // Reset during PRESS of candidate 3
    load_vm(vt[4]);
    base = cyc; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < base + 15) begin
      @(posedge clk); #1;
    end
    chk("mid_button3", button3, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mode", mode, 1'b0);
    chk("rst_buttons", {button4, button3, button2, button1}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_counts", {count1, count2, count3, count4}, 32'd0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    run_readout(vt[0], 1'b0);

    // start held high: two back-to-back readouts
    load_vm(vt[1]);
    x.v = vt[1];
    x.dc = cyc + 1 + LAT;
    q.push_back(x);
    x.dc = cyc + 1 + (LAT + 2) + LAT;
    q.push_back(x);
    d0 = done_cnt; p0 = presses;
    start = 1'b1;
    wait_dones(d0 + 2, 200);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_press_count", presses - p0, 8);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
- Reads out a finished election from the voting machine.
- Where a test driver or the user normally works mode and button1..button4 by hand, this block drives them itself.
- Puts the voting machine in result mode, presses each candidate button in turn and samples the 8-bit led bus for that candidate's count.
- Latches all four counts, then reports the winner and a tie flag. Sits between the voting machine and the display/reporting logic.

Parameters:
- SETTLE_CYCLES, 4: cycles a candidate button is held before led is sampled (covers the voting machine's button-to-led latency); legal range 1..255.
- GAP_CYCLES, 2: cycles with all buttons low on result-mode entry and between candidates; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a readout; sampled only in IDLE.
- led_in  in  8  voting machine led output (candidate count while its button is held in result mode).
- mode  out  1  to voting machine; 1 = result mode.
- button1..button4  out  1 each  to voting machine; at most one high in any cycle.
- count1..count4  out  8 each  latched candidate counts.
- winner  out  2  index of winning candidate, 0 = candidate 1 .. 3 = candidate 4.
- tie  out  1  maximum count shared by two or more candidates.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse when results are valid.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: mode, buttons, busy, done, tie = 0; winner = 0; count1..4 = 0; FSM = IDLE; internal counters = 0.
- Reset mid-operation: at the next edge the FSM returns to IDLE; mode and all buttons read 0 after that edge; the partial counts are cleared.
- FSM states are IDLE, ENTER, PRESS, RELEASE, COMPARE, DONE. A 2-bit index k (0..3) and an 8-bit cycle counter run alongside.
- IDLE: outputs are quiet (mode 0, buttons 0, busy 0).
  - On start=1 at edge N: go to ENTER, clear count1..4, tie and winner, set k=0.
  - From edge N onward: busy=1, mode=1.
- ENTER: mode=1, buttons 0, lasts GAP_CYCLES, then PRESS.
- PRESS: mode=1, button(k+1)=1, all other buttons 0, lasts SETTLE_CYCLES.
  - On the edge that leaves PRESS, led_in is captured into count(k+1).
  - Next state is RELEASE.
- RELEASE: mode=1, buttons 0, lasts GAP_CYCLES.
  - If k<3: k increments and the FSM goes to PRESS.
  - If k=3: the FSM goes to COMPARE.
- COMPARE: one cycle, mode=0, busy=1.
  - winner = index of the maximum count; on equal counts the lowest index wins.
  - tie = 1 if two or more counts equal the maximum (all-zero gives tie=1, winner=0).
  - Comparison is unsigned 8-bit.
- DONE: one cycle with done=1 and busy=0; the FSM then returns to IDLE.
- Timing: done is high in the cycle following edge N + GAP_CYCLES + 4*(SETTLE_CYCLES+GAP_CYCLES) + 1. With the default parameters that is N+27.
- Holding results: count1..4, winner and tie hold after DONE until the next accepted start or reset.
- start handling:
  - start while busy or in DONE is ignored (no restart, no queueing).
  - start held high continuously gives back-to-back readouts, each starting from IDLE.
- Outputs and output-change rules:
  - All outputs are registered.
  - Button transitions always pass through an all-low cycle.
  - mode never falls while a button is high.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, then low for 10 cycles with start=0 -> mode, buttons, busy, done = 0; counts = 0.
- Normal readout: a behavioural voting-machine model holds counts 3,7,2,5; start pulse -> button1..4 each high for exactly 4 cycles in order with 2-cycle gaps, mode high for 26 cycles; done at N+27; count1..4 = 3,7,2,5; winner=1; tie=0.
- Tie: model counts 9,4,9,1 -> winner=0, tie=1. All-zero model -> winner=0, tie=1.
- Reset mid-readout: assert reset during PRESS of candidate 3 -> next edge has mode=0, buttons=0, busy=0, counts=0, no done pulse. A following start completes a normal readout.
- start ignored while busy: pulse start again at N+10 -> exactly one done pulse at N+27, no extra button sequence.
- One-hot and sequencing check across the whole run:
  - never more than one button high;
  - never a direct button-to-button transition without an all-low cycle;
  - never a button high while mode=0;
  - mode never falls while a button is high.
